// File: rtl/rfnoc_qpsk_pkg.sv
// ============================================================================
// Module      : rfnoc_qpsk_pkg
// Description : Types and constants shared by the QPSK dibit/word converters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rfnoc_qpsk_pkg;

  localparam int DIBITS_PER_WORD = 16;
  localparam int DIBIT_W         = 2;

  typedef logic [DIBIT_W-1:0] dibit_t;
  typedef logic [31:0]        word_t;

  // Append one dibit at the LSB end so the oldest dibit migrates toward [31:30].
  function automatic word_t shift_in_dibit(input word_t w, input dibit_t d);
    return {w[31-DIBIT_W:0], d};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rfnoc_conv2bto32b_core.sv
// ============================================================================
// Module      : rfnoc_conv2bto32b_core
// Description : Decimates a repeated-dibit item stream by N and packs 16
//               surviving dibits MSB-first into 32-bit AXI-Stream words with
//               fixed-length packet framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rfnoc_conv2bto32b_core
  import rfnoc_qpsk_pkg::*;
#(
  parameter int ITEM_W    = 32,
  parameter int N         = 4,
  parameter int PKT_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ITEM_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [3:0]        sym_count
);

  // Counter widths cover the full legal parameter ranges (N<=255, PKT_WORDS<=4096).
  localparam logic [7:0]  PHASE_LAST = 8'(N - 1);
  localparam logic [11:0] WORD_LAST  = 12'(PKT_WORDS - 1);
  localparam logic [3:0]  SYM_LAST   = 4'(DIBITS_PER_WORD - 1);

  logic [7:0]  phase_q, phase_d;
  logic [3:0]  sym_q,   sym_d;
  word_t       shreg_q, shreg_d;
  word_t       data_q,  data_d;
  logic        valid_q, valid_d;
  logic        last_q,  last_d;
  logic [11:0] wcnt_q,  wcnt_d;

  logic   w_in_beat;
  logic   w_keep;
  logic   w_complete;
  logic   w_drain;
  dibit_t w_dibit;
  word_t  w_packed;

  // Input only stalls while a finished word is stuck at the output.
  assign s_axis_tready = !(rst || clear) && (!valid_q || m_axis_tready);

  assign w_in_beat  = s_axis_tvalid && s_axis_tready;
  assign w_keep     = w_in_beat && (phase_q == '0);
  assign w_complete = w_keep && (sym_q == SYM_LAST);
  assign w_drain    = valid_q && m_axis_tready;
  assign w_dibit    = s_axis_tdata[DIBIT_W-1:0];
  assign w_packed   = shift_in_dibit(shreg_q, w_dibit);

  // Only the dibit field carries information; framing on the input is ignored.
  generate
    if (ITEM_W > DIBIT_W) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^s_axis_tdata[ITEM_W-1:DIBIT_W];
    end
  endgenerate

  logic w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;

  // Next-state for decimation phase, packer, output register and word counter.
  always_comb begin
    phase_d = phase_q;
    sym_d   = sym_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;

    if (w_drain) begin
      wcnt_d  = (wcnt_q == WORD_LAST) ? '0 : wcnt_q + 12'd1;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (w_in_beat) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 8'd1;
    end

    if (w_keep) begin
      shreg_d = w_packed;
      sym_d   = (sym_q == SYM_LAST) ? '0 : sym_q + 4'd1;
    end

    // A completion in the same cycle as a drain overrides the drain, so the
    // output stays valid with fresh data and no bubble is inserted.
    if (w_complete) begin
      valid_d = 1'b1;
      data_d  = w_packed;
      last_d  = (wcnt_d == WORD_LAST);
    end
  end

  // State registers; clear behaves exactly like reset and drops any partial word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase_q <= '0;
      sym_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      sym_q   <= sym_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign sym_count     = sym_q;

endmodule

`default_nettype wire

// File: tb/tb_rfnoc_conv2bto32b_core.sv
// ============================================================================
// Module      : tb_rfnoc_conv2bto32b_core
// Description : Directed self-checking bench; three core instances cover
//               (N=4,PKT=2), (N=1,PKT=1) and (N=4,PKT=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rfnoc_conv2bto32b_core;

  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_tdata  [3];
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic        s_tlast  [3];
  logic [31:0] m_tdata  [3];
  logic        m_tvalid [3];
  logic        m_tready [3];
  logic        m_tlast  [3];
  logic [3:0]  symc     [3];
  logic        clr      [3];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] in_mem  [3][DEPTH];
  int          in_wr   [3] = '{0, 0, 0};
  int          in_rd   [3] = '{0, 0, 0};
  int          in_stall[3] = '{0, 0, 0};
  int          out_stall[3] = '{0, 0, 0};
  bit          out_hold[3] = '{0, 0, 0};
  bit          acc     [3] = '{0, 0, 0};
  logic [32:0] out_mem [3][256];
  int          out_cnt [3] = '{0, 0, 0};

  rfnoc_conv2bto32b_core #(.ITEM_W(32), .N(4), .PKT_WORDS(2)) dut_a (
    .clk(clk), .rst(rst), .clear(clr[0]),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .s_axis_tlast(s_tlast[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]), .sym_count(symc[0]));

  rfnoc_conv2bto32b_core #(.ITEM_W(32), .N(1), .PKT_WORDS(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clr[1]),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .s_axis_tlast(s_tlast[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]), .sym_count(symc[1]));

  rfnoc_conv2bto32b_core #(.ITEM_W(32), .N(4), .PKT_WORDS(16)) dut_c (
    .clk(clk), .rst(rst), .clear(clr[2]),
    .s_axis_tdata(s_tdata[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
    .s_axis_tlast(s_tlast[2]), .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]),
    .m_axis_tready(m_tready[2]), .m_axis_tlast(m_tlast[2]), .sym_count(symc[2]));

  // Source/sink driver: updates inputs 1 time unit after each rising edge.
  initial begin
    for (int k = 0; k < 3; k++) begin
      s_tvalid[k] = 1'b0;
      s_tdata[k]  = '0;
      s_tlast[k]  = 1'b0;
      m_tready[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) in_rd[k]++;
        if (!(s_tvalid[k] && !acc[k])) begin
          s_tvalid[k] = (in_rd[k] < in_wr[k]) && ($urandom_range(99) >= in_stall[k]);
          s_tdata[k]  = in_mem[k][in_rd[k] % DEPTH];
          s_tlast[k]  = 1'($urandom_range(1));
        end
        m_tready[k] = !out_hold[k] && ($urandom_range(99) >= out_stall[k]);
      end
    end
  end

  // Monitor on the falling edge: records handshakes that the next rising edge completes.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        acc[k] = s_tvalid[k] && s_tready[k];
        if (m_tvalid[k] === 1'b1 && m_tready[k] === 1'b1) begin
          out_mem[k][out_cnt[k] % 256] = {m_tlast[k], m_tdata[k]};
          out_cnt[k]++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push_word(input int k, input logic [31:0] w, input int rep, input bit pad);
    logic [31:0] it;
    for (int i = 15; i >= 0; i--) begin
      for (int r = 0; r < rep; r++) begin
        it      = $urandom;
        it[1:0] = (pad && r != 0) ? 2'b11 : w[2*i +: 2];
        in_mem[k][in_wr[k] % DEPTH] = it;
        in_wr[k]++;
      end
    end
  endtask

  task automatic wait_out(input int k, input int n, input int budget, output bit to);
    int c = 0;
    while (out_cnt[k] < n && c < budget) begin
      @(negedge clk);
      #2;
      c++;
    end
    to = (out_cnt[k] < n);
  endtask

  task automatic wait_in(input int k, output bit to);
    int c = 0;
    while (in_rd[k] < in_wr[k] && c < 5000) begin
      @(negedge clk);
      #2;
      c++;
    end
    to = (in_rd[k] < in_wr[k]);
  endtask

  task automatic test_reset;
    logic [38:0] got;
    repeat (2) @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      got = {s_tready[k], m_tvalid[k], m_tlast[k], symc[k], m_tdata[k]};
      n_vec++;
      if (got !== 39'd0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got %h expected 0", k, got);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    #2;
    n_vec++;
    if ({s_tready[0], s_tready[1], s_tready[2]} !== 3'b111) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b expected 111",
               {s_tready[0], s_tready[1], s_tready[2]});
    end
  endtask

  task automatic test_pack;
    int base = out_cnt[0];
    bit to;
    push_word(0, 32'h5ACFFC1D, 4, 1'b0);
    push_word(0, 32'hA53003E2, 4, 1'b0);
    wait_out(0, base + 2, 2000, to);
    n_vec++;
    if (to) begin n_bad++; $display("FAIL pack_timeout: got %0d words expected 2", out_cnt[0] - base); end
    n_vec++;
    if (out_mem[0][base % 256] !== {1'b0, 32'h5ACFFC1D}) begin
      n_bad++; $display("FAIL pack_word0: got %h expected %h", out_mem[0][base % 256], {1'b0, 32'h5ACFFC1D});
    end
    n_vec++;
    if (out_mem[0][(base + 1) % 256] !== {1'b1, 32'hA53003E2}) begin
      n_bad++; $display("FAIL pack_word1: got %h expected %h", out_mem[0][(base + 1) % 256], {1'b1, 32'hA53003E2});
    end
  endtask

  task automatic test_first_copy;
    int base = out_cnt[0];
    bit to;
    push_word(0, 32'h12345678, 4, 1'b1);
    wait_out(0, base + 1, 2000, to);
    n_vec++;
    if (to || out_mem[0][base % 256] !== {1'b0, 32'h12345678}) begin
      n_bad++; $display("FAIL phase0_only: got %h expected %h (timeout=%0d)", out_mem[0][base % 256], {1'b0, 32'h12345678}, to);
    end
  endtask

  task automatic test_n1_latency;
    bit found = 1'b0;
    bit to;
    push_word(1, 32'h66666666, 1, 1'b0);
    push_word(1, 32'h66666666, 1, 1'b0);
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      #2;
      if (acc[1] && in_rd[1] == 15) found = 1'b1;
    end
    n_vec++;
    if (!found || m_tvalid[1] !== 1'b0) begin
      n_bad++; $display("FAIL n1_pre_valid: got valid=%b found=%0d expected valid=0", m_tvalid[1], found);
    end
    @(negedge clk);
    #2;
    n_vec++;
    if ({m_tvalid[1], m_tlast[1], m_tdata[1]} !== {2'b11, 32'h66666666}) begin
      n_bad++; $display("FAIL n1_latency: got %b %b %h expected 1 1 66666666", m_tvalid[1], m_tlast[1], m_tdata[1]);
    end
    wait_out(1, 2, 500, to);
    n_vec++;
    if (to || out_mem[1][0] !== {1'b1, 32'h66666666} || out_mem[1][1] !== {1'b1, 32'h66666666}) begin
      n_bad++; $display("FAIL n1_words: got %h %h expected 166666666 twice (timeout=%0d)", out_mem[1][0], out_mem[1][1], to);
    end
  endtask

  task automatic test_backpressure;
    int base    = out_cnt[0];
    int base_in = in_wr[0];
    bit found   = 1'b0;
    bit stable  = 1'b1;
    bit to;
    out_hold[0] = 1'b1;
    push_word(0, 32'h0F1E2D3C, 4, 1'b0);
    push_word(0, 32'hC3B4A596, 4, 1'b0);
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      #2;
      if (m_tvalid[0] === 1'b1) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_bad++; $display("FAIL hold_valid: got valid=0 expected 1"); end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #2;
      if (!(m_tvalid[0] === 1'b1 && m_tdata[0] === 32'h0F1E2D3C && m_tlast[0] === 1'b1 && s_tready[0] === 1'b0))
        stable = 1'b0;
    end
    n_vec++;
    if (!stable) begin
      n_bad++; $display("FAIL hold_stable: got %b %h %b ready=%b expected 1 0f1e2d3c 1 ready=0", m_tvalid[0], m_tdata[0], m_tlast[0], s_tready[0]);
    end
    n_vec++;
    if (in_rd[0] - base_in != 61) begin
      n_bad++; $display("FAIL hold_input_stall: got %0d items consumed expected 61", in_rd[0] - base_in);
    end
    out_hold[0] = 1'b0;
    wait_out(0, base + 2, 2000, to);
    n_vec++;
    if (to || out_mem[0][base % 256] !== {1'b1, 32'h0F1E2D3C}) begin
      n_bad++; $display("FAIL hold_word0: got %h expected %h", out_mem[0][base % 256], {1'b1, 32'h0F1E2D3C});
    end
    n_vec++;
    if (out_mem[0][(base + 1) % 256] !== {1'b0, 32'hC3B4A596}) begin
      n_bad++; $display("FAIL hold_word1: got %h expected %h", out_mem[0][(base + 1) % 256], {1'b0, 32'hC3B4A596});
    end
  endtask

  task automatic test_clear;
    int base;
    bit to;
    logic [31:0] it;
    for (int i = 0; i < 28; i++) begin
      it = $urandom;
      it[1:0] = 2'b10;
      in_mem[0][in_wr[0] % DEPTH] = it;
      in_wr[0]++;
    end
    wait_in(0, to);
    @(negedge clk);
    #2;
    n_vec++;
    if (to || symc[0] !== 4'd7) begin
      n_bad++; $display("FAIL clear_pre_symcount: got %0d expected 7 (timeout=%0d)", symc[0], to);
    end
    clr[0] = 1'b1;
    #1;
    n_vec++;
    if (s_tready[0] !== 1'b0) begin n_bad++; $display("FAIL clear_ready: got %b expected 0", s_tready[0]); end
    @(negedge clk);
    #2;
    clr[0] = 1'b0;
    #1;
    n_vec++;
    if (symc[0] !== 4'd0 || s_tready[0] !== 1'b1) begin
      n_bad++; $display("FAIL clear_state: got sym=%0d ready=%b expected sym=0 ready=1", symc[0], s_tready[0]);
    end
    base = out_cnt[0];
    push_word(0, 32'hDEADBEEF, 4, 1'b0);
    wait_out(0, base + 1, 2000, to);
    n_vec++;
    if (to || out_mem[0][base % 256] !== {1'b0, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL clear_word: got %h expected %h (timeout=%0d)", out_mem[0][base % 256], {1'b0, 32'hDEADBEEF}, to);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_w [64];
    int base = out_cnt[2];
    bit to;
    in_stall[2]  = 25;
    out_stall[2] = 25;
    for (int i = 0; i < 64; i++) begin
      exp_w[i] = $urandom;
      push_word(2, exp_w[i], 4, 1'b0);
    end
    wait_out(2, base + 64, 20000, to);
    n_vec++;
    if (to) begin n_bad++; $display("FAIL random_timeout: got %0d words expected 64", out_cnt[2] - base); end
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if (out_mem[2][(base + i) % 256] !== {(i % 16) == 15, exp_w[i]}) begin
        n_bad++; $display("FAIL random_word%0d: got %h expected %h", i, out_mem[2][(base + i) % 256], {(i % 16) == 15, exp_w[i]});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) clr[k] = 1'b0;
    test_reset;
    test_pack;
    test_first_copy;
    test_n1_latency;
    test_backpressure;
    test_clear;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rfnoc_conv2bto32b_core.md
Name: rfnoc_conv2Bto32B_core

Overview:
Receive-side inverse of the 32-bit-to-dibit converter in the QPSK chain. Consumes an AXI-Stream of 32-bit items, each carrying one 2-bit symbol in bits [1:0]; each symbol is repeated N times. The block decimates by N, packs 16 surviving dibits MSB-first into one 32-bit word, and emits words on an AXI-Stream with packet framing. It sits inside the rfnoc_block_conv2Bto32B shell, between the input and output AXIS data paths.

Parameters:
ITEM_W, 32, input item width; only bits [1:0] are used.
N, 4, symbol repetition factor; legal range 1..255.
PKT_WORDS, 64, output words per packet; m_axis_tlast marks the last word; legal range 1..4096.

Ports:
clk  in  1  data-path clock
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous soft clear; same effect as rst on all state
s_axis_tdata  in  ITEM_W  input item; dibit in [1:0]
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  ignored; input framing does not affect packing
m_axis_tdata  out  32  packed word
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last word of output packet
sym_count  out  4  number of dibits currently packed in the partial word (0..15); status only

Behaviour:
- Reset values (rst or clear): s_axis_tready=0 during the reset cycle, then 1. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, sym_count=0, phase counter=0, word counter=0, shift register=0. Any partial word is discarded.
- Input beat: s_axis_tvalid && s_axis_tready.
- s_axis_tready = !m_axis_tvalid || m_axis_tready, and it is 0 during rst/clear. Input stalls only while a completed word is waiting.
- Phase counter (0..N-1): increments on each input beat and wraps from N-1 to 0. Only the beat with phase==0 is kept; the other N-1 beats are consumed and discarded. With N=1, every beat is kept.
- Pack on a kept beat: shreg <= {shreg[29:0], s_axis_tdata[1:0]} and sym_count increments. The first kept dibit ends up in bits [31:30].
- On the 16th kept dibit (sym_count==15 on a kept beat):
  - The next cycle shows m_axis_tvalid=1 and m_axis_tdata={shreg[29:0], dibit}.
  - sym_count wraps to 0.
  - Latency is 1 cycle from the accepting edge.
- Output holding: m_axis_tdata and m_axis_tlast are held stable while m_axis_tvalid && !m_axis_tready. m_axis_tvalid falls after the handshake unless a new word completes in the same cycle.
- Simultaneous completion and drain: if the output handshake and a new word completion occur in the same cycle, m_axis_tvalid stays 1 and the data updates. Throughput is one word per 16*N input beats, with no bubbles.
- Word counter (0..PKT_WORDS-1): m_axis_tlast = (word counter == PKT_WORDS-1) for the presented word. The counter advances on each output handshake and wraps to 0 after tlast.
- Input bits [ITEM_W-1:2] are ignored. Input tlast does not reset the phase or packing state.
- rst or clear asserted mid-packet drops the partial word and any pending output word. The next kept dibit becomes bits [31:30] of a fresh word, and the next output word is word 0 of a new packet.

Decomposition:
- Shared package rfnoc_qpsk_pkg holds:
  - localparam DIBITS_PER_WORD=16
  - localparam DIBIT_W=2
  - typedef logic [1:0] dibit_t
  - typedef logic [31:0] word_t
  - the same package the 32B-to-2B converter uses
- No sub-module: the phase counter, packer and output register form a single module.
- The rfnoc_block_conv2Bto32B shell instantiates this core, with its user register driving clear.

Test Plan:
1. N=4, PKT_WORDS=2, 128 items with the dibits of 0x5ACFFC1D then 0xA53003E2, each repeated 4 times -> words 0x5ACFFC1D (tlast=0) then 0xA53003E2 (tlast=1).
2. N=4, non-repeated first copy: each group is {d, 3, 3, 3} with d the dibits of 0x12345678 -> 0x12345678. This proves only phase-0 beats are kept.
3. N=1, PKT_WORDS=1, 32 items of alternating dibits 01/10 -> two words 0x66666666, each with tlast=1, and a 1-cycle latency check.
4. m_axis_tready=0 for 100 cycles after the first word completes, with continuous input -> word held stable, s_axis_tready=0 while full, no data lost, second word correct after release.
5. Assert clear after 7 kept dibits (sym_count=7), then feed a full 0xDEADBEEF sequence -> output exactly 0xDEADBEEF with tlast status reset to word 0.
6. 25% random stalls on both interfaces, 64 random words, N=4, PKT_WORDS=16 -> output equals input in order, and tlast falls on words 16, 32, 48 and 64.
